// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data-memory responder.
// Byte/half/word loads and stores on a big-endian byte array, answered with a
// one-cycle mem_ready pulse after WAIT_STATES wait cycles.
// Optional feature macro: DMEM_STICKY_ERR_EN adds the err_sticky output, set
// by any faulted request and cleared only by reset.
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE
// and mem_enable = 1 (no back-pressure signal; mem_busy = 1 means inputs are
// being ignored). The single response is the cycle with mem_ready = 1;
// data_out and misalign_err are meaningful only in that cycle.
module data_mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_enable,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_se,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              mem_busy,
  output logic              mem_ready,
  output logic              misalign_err,
  output logic [1:0]        state_dbg
`ifdef DMEM_STICKY_ERR_EN
  ,
  output logic              err_sticky
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Counter preload: WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t state;
  state_t next_state;

  logic [3:0]        wait_cnt;
  logic              rw_q;
  logic [1:0]        size_q;
  logic              se_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              resp_fault;

  logic capture;
  logic enter_resp;

  // Effective request: live inputs while IDLE (only matters when
  // WAIT_STATES = 0 and capture and RESP entry share one edge), captured copy
  // otherwise.
  logic              eff_rw;
  logic [1:0]        eff_size;
  logic              eff_se;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0]       eff_wdata;
  logic              eff_fault;
  logic              write_fire;

  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       rd_value;

  logic [7:0] mem [DEPTH];

  // Select live or captured request fields.
  always_comb begin
    if (state == S_IDLE) begin
      eff_rw    = mem_rw;
      eff_size  = mem_size;
      eff_se    = mem_se;
      eff_addr  = address;
      eff_wdata = data_in;
    end else begin
      eff_rw    = rw_q;
      eff_size  = size_q;
      eff_se    = se_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
    end
  end

  // Alignment check plus big-endian byte gather and load extension.
  always_comb begin
    eff_fault = 1'b0;
    case (eff_size)
      SIZE_BYTE: eff_fault = 1'b0;
      SIZE_HALF: eff_fault = eff_addr[0];
      SIZE_WORD: eff_fault = (eff_addr[1:0] != 2'b00);
      default:   eff_fault = 1'b1;
    endcase

    a0 = eff_addr;
    a1 = eff_addr + ADDR_W'(1);
    a2 = eff_addr + ADDR_W'(2);
    a3 = eff_addr + ADDR_W'(3);
    b0 = mem[a0];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];

    rd_value = 32'd0;
    case (eff_size)
      SIZE_BYTE: rd_value = eff_se ? {{24{b0[7]}}, b0} : {24'd0, b0};
      SIZE_HALF: rd_value = eff_se ? {{16{b0[7]}}, b0, b1} : {16'd0, b0, b1};
      SIZE_WORD: rd_value = {b0, b1, b2, b3};
      default:   rd_value = 32'd0;
    endcase
    if (eff_fault) rd_value = 32'd0;
  end

  assign write_fire = enter_resp & eff_rw & ~eff_fault;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // FSM next state and decoded outputs.
  always_comb begin
    next_state   = state;
    capture      = 1'b0;
    enter_resp   = 1'b0;
    mem_busy     = 1'b0;
    mem_ready    = 1'b0;
    misalign_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_enable) begin
          capture = 1'b1;
          if (WAIT_STATES > 0) begin
            next_state = S_WAIT;
          end else begin
            next_state = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        mem_busy = 1'b1;
        if (wait_cnt == 4'd0) begin
          next_state = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        mem_busy     = 1'b1;
        mem_ready    = 1'b1;
        misalign_err = resp_fault;
        next_state   = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign state_dbg = state;

  // Request capture and wait-state countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
      rw_q     <= 1'b0;
      size_q   <= 2'b00;
      se_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
    end else if (capture) begin
      wait_cnt <= WAIT_LOAD;
      rw_q     <= mem_rw;
      size_q   <= mem_size;
      se_q     <= mem_se;
      addr_q   <= address;
      wdata_q  <= data_in;
    end else if (state == S_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Response data and fault flag, latched on the edge entering RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= 32'd0;
      resp_fault <= 1'b0;
    end else if (enter_resp) begin
      resp_fault <= eff_fault;
      if (eff_fault || !eff_rw) data_out <= rd_value;
    end
  end

`ifdef DMEM_STICKY_ERR_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        err_sticky <= 1'b0;
    else if (enter_resp && eff_fault)  err_sticky <= 1'b1;
  end
`endif

  // Store path; storage is never reset, and reset forces IDLE so an aborted
  // request can never reach write_fire.
  always_ff @(posedge clk) begin
    if (write_fire) begin
      case (eff_size)
        SIZE_BYTE: mem[a0] <= eff_wdata[7:0];
        SIZE_HALF: begin
          mem[a0] <= eff_wdata[15:8];
          mem[a1] <= eff_wdata[7:0];
        end
        SIZE_WORD: begin
          mem[a0] <= eff_wdata[31:24];
          mem[a1] <= eff_wdata[23:16];
          mem[a2] <= eff_wdata[15:8];
          mem[a3] <= eff_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule
